store_buffer: RTL and testbench

//  Posted-write buffer between the RiSC-16 MEM stage and data_memory. Stores are

---
 rtl/risc_pkg.sv | 19 +
 rtl/sb_fwd_match.sv | 41 ++++
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Brief    : Shared word width and memory-port arbitration select encoding.
// Revision : 1.0
// ============================================================================
package risc_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      SEL_IDLE  = 2'd0,
      SEL_DBG   = 2'd1,
      SEL_LOAD  = 2'd2,
      SEL_DRAIN = 2'd3
   } mem_sel_e;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_match
// Brief    : Youngest-match search over the valid store-buffer entries.
// Revision : 1.0
// ============================================================================
module sb_fwd_match
   import risc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = WORD_W,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = PTR_W + 1
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
   input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
   input  logic [PTR_W-1:0]             head,
   input  logic [CNT_W-1:0]             count,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);

   // Walk oldest to youngest so a later (younger) match overrides an earlier one.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      hit   = 1'b0;
      data  = '0;
      w_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && (entry_addr[w_idx] == req_addr)) begin
            hit  = 1'b1;
            data = entry_data[w_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO in front of data memory with load forwarding.
// Revision : 1.0
// ============================================================================
module store_buffer
   import risc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic [DATA_W-1:0] load_data,
   input  logic              dbg_valid,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [PTR_W-1:0]             r_head;
   logic [PTR_W-1:0]             r_tail;
   logic [CNT_W-1:0]             r_count;

   mem_sel_e          w_sel;
   logic              w_push;
   logic              w_pop;
   logic              w_hit;
   logic [DATA_W-1:0] w_fwd_data;

   assign sb_empty  = (r_count == '0);
   assign req_ready = req_we ? (r_count != c_full) : ~dbg_valid;
   assign w_push    = req_valid & req_we & req_ready;
   assign w_pop     = (w_sel == SEL_DRAIN);
   assign dbg_rdata = mem_rdata;
   assign load_data = w_hit ? w_fwd_data : mem_rdata;

   always_comb begin
      w_sel = SEL_IDLE;
      if (dbg_valid)
         w_sel = SEL_DBG;
      else if (req_valid && !req_we)
         w_sel = SEL_LOAD;
      else if (!sb_empty)
         w_sel = SEL_DRAIN;
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (w_sel)
         SEL_DBG: begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         SEL_LOAD: begin
            mem_addr  = req_addr;
         end
         SEL_DRAIN: begin
            mem_we    = 1'b1;
            mem_addr  = r_addr[r_head];
            mem_wdata = r_data[r_head];
         end
         default: begin
         end
      endcase
   end

   // Entry payload is deliberately left out of reset; only pointers/count qualify it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= req_addr;
         r_data[r_tail] <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_tail <= r_tail + PTR_W'(1);
         if (w_pop)
            r_head <= r_head + PTR_W'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CNT_W'(1);
      end
   end

   sb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W),
      .CNT_W  (CNT_W)
   ) u_fwd (
      .entry_addr (r_addr),
      .entry_data (r_data),
      .head       (r_head),
      .count      (r_count),
      .req_addr   (req_addr),
      .hit        (w_hit),
      .data       (w_fwd_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed vector bench for store_buffer with a 256-word memory model.
// Revision : 1.0
// ============================================================================
module tb_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready;
   logic [15:0] load_data;
   logic        dbg_valid, dbg_we;
   logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        sb_empty;

   logic [15:0] mem [0:255];
   logic [15:0] drain_log [0:63];
   int          log_n = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   typedef struct {
      string       name;
      logic        rv, rwe;
      logic [15:0] ra, rd;
      logic        dv, dwe;
      logic [15:0] da, dd;
      logic        e_rdy, c_ld;
      logic [15:0] e_ld;
      logic        e_we;
      logic [15:0] e_ma, e_mwd;
      logic        e_emp;
   } vec_t;

   store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .load_data(load_data),
      .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .sb_empty(sb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_we && !dbg_valid) begin
         drain_log[log_n[5:0]] <= mem_addr;
         log_n <= log_n + 1;
      end
   end

   function automatic vec_t mk(input string n,
                               input logic rv, input logic rwe,
                               input logic [15:0] ra, input logic [15:0] rd,
                               input logic dv, input logic dwe,
                               input logic [15:0] da, input logic [15:0] dd,
                               input logic rdy, input logic cld, input logic [15:0] ld,
                               input logic we, input logic [15:0] ma,
                               input logic [15:0] mwd, input logic emp);
      vec_t v;
      v.name = n; v.rv = rv; v.rwe = rwe; v.ra = ra; v.rd = rd;
      v.dv = dv; v.dwe = dwe; v.da = da; v.dd = dd;
      v.e_rdy = rdy; v.c_ld = cld; v.e_ld = ld; v.e_we = we;
      v.e_ma = ma; v.e_mwd = mwd; v.e_emp = emp;
      return v;
   endfunction

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   // Drive one cycle just after the rising edge, compare on the falling edge.
   task automatic run_vec(input vec_t v);
      @(posedge clk);
      #1;
      req_valid = v.rv; req_we = v.rwe; req_addr = v.ra; req_wdata = v.rd;
      dbg_valid = v.dv; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dd;
      @(negedge clk);
      chk({v.name, ".req_ready"}, {15'd0, req_ready}, {15'd0, v.e_rdy});
      chk({v.name, ".mem_we"},    {15'd0, mem_we},    {15'd0, v.e_we});
      chk({v.name, ".mem_addr"},  mem_addr,  v.e_ma);
      chk({v.name, ".mem_wdata"}, mem_wdata, v.e_mwd);
      chk({v.name, ".sb_empty"},  {15'd0, sb_empty},  {15'd0, v.e_emp});
      if (v.c_ld) chk({v.name, ".load_data"}, load_data, v.e_ld);
   endtask

   vec_t tbl [16];

   initial begin
      int base;
      logic [15:0] a, d;

      //               name       rv rwe  ra     rd     dv dwe  da     dd     rdy cld ld     we ma     mwd    emp
      tbl[0]  = mk("pre30",   0, 0, 16'h0, 16'h0, 1, 1, 16'h30, 16'h5A5A, 0, 0, 16'h0, 1, 16'h30, 16'h5A5A, 1);
      tbl[1]  = mk("pre70",   0, 0, 16'h0, 16'h0, 1, 1, 16'h70, 16'hDEAD, 0, 0, 16'h0, 1, 16'h70, 16'hDEAD, 1);
      tbl[2]  = mk("pre71",   0, 0, 16'h0, 16'h0, 1, 1, 16'h71, 16'hDEAD, 0, 0, 16'h0, 1, 16'h71, 16'hDEAD, 1);
      tbl[3]  = mk("pre72",   0, 0, 16'h0, 16'h0, 1, 1, 16'h72, 16'hDEAD, 0, 0, 16'h0, 1, 16'h72, 16'hDEAD, 1);
      tbl[4]  = mk("t1_st",   1, 1, 16'h10, 16'hABCD, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 1);
      tbl[5]  = mk("t1_drn",  0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 1, 16'h10, 16'hABCD, 0);
      tbl[6]  = mk("t1_emp",  0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 1);
      tbl[7]  = mk("t2_st1",  1, 1, 16'h20, 16'h1111, 1, 0, 16'h10, 16'h0, 1, 0, 16'h0, 0, 16'h10, 16'h0, 1);
      tbl[8]  = mk("t2_st2",  1, 1, 16'h20, 16'h2222, 1, 0, 16'h10, 16'h0, 1, 0, 16'h0, 0, 16'h10, 16'h0, 0);
      tbl[9]  = mk("t2_ld",   1, 0, 16'h20, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h2222, 0, 16'h20, 16'h0, 0);
      tbl[10] = mk("t2_drn1", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 1, 16'h20, 16'h1111, 0);
      tbl[11] = mk("t2_drn2", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 1, 16'h20, 16'h2222, 0);
      tbl[12] = mk("t2_emp",  0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 1);
      tbl[13] = mk("t3_ld30", 1, 0, 16'h30, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h5A5A, 0, 16'h30, 16'h0, 1);
      tbl[14] = mk("t3_ld20", 1, 0, 16'h20, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h2222, 0, 16'h20, 16'h0, 1);
      tbl[15] = mk("t3_ld10", 1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, 16'hABCD, 0, 16'h10, 16'h0, 1);

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b1; req_addr = '0; req_wdata = '0;
      dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      #3;
      chk("rst.sb_empty",  {15'd0, sb_empty},  16'd1);
      chk("rst.mem_we",    {15'd0, mem_we},    16'd0);
      chk("rst.mem_addr",  mem_addr,           16'h0);
      chk("rst.req_ready", {15'd0, req_ready}, 16'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(tbl[i]);

      // Debug read holds the port: fill the queue, then 5th store stalls.
      for (int i = 0; i < 4; i++)
         run_vec(mk("t4_fill", 1, 1, 16'h50 + 16'(i), 16'h4000 + 16'(i), 1, 0, 16'h30, 16'h0,
                    1, 0, 16'h0, 0, 16'h30, 16'h0, (i == 0)));
      chk("t4_dbg_rdata", dbg_rdata, 16'h5A5A);
      repeat (2)
         run_vec(mk("t4_full", 1, 1, 16'h54, 16'h4004, 1, 0, 16'h30, 16'h0,
                    0, 0, 16'h0, 0, 16'h30, 16'h0, 0));
      run_vec(mk("t4_rel", 1, 1, 16'h54, 16'h4004, 0, 0, 16'h0, 16'h0,
                 0, 0, 16'h0, 1, 16'h50, 16'h4000, 0));
      run_vec(mk("t4_acc", 1, 1, 16'h54, 16'h4004, 0, 0, 16'h0, 16'h0,
                 1, 0, 16'h0, 1, 16'h51, 16'h4001, 0));
      for (int i = 2; i < 5; i++)
         run_vec(mk("t4_drn", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0,
                    1, 0, 16'h0, 1, 16'h50 + 16'(i), 16'h4000 + 16'(i), 0));
      run_vec(mk("t4_emp", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0,
                 1, 0, 16'h0, 0, 16'h0, 16'h0, 1));
      for (int i = 0; i < 5; i++)
         chk("t4_mem", mem[8'h50 + 8'(i)], 16'h4000 + 16'(i));

      // Store / load / idle rounds; pointers wrap after four entries.
      base = log_n;
      for (int i = 0; i < 10; i++) begin
         a = 16'h60 + 16'(i);
         d = 16'h6000 + 16'(i) * 16'h0101;
         run_vec(mk("t5_st", 1, 1, a, d, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 1));
         run_vec(mk("t5_ld", 1, 0, a, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, d, 0, a, 16'h0, 0));
         run_vec(mk("t5_drn", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 1, a, d, 0));
      end
      @(negedge clk);
      chk("t5_log_n", 16'(log_n - base), 16'd10);
      for (int i = 0; i < 10; i++) begin
         chk("t5_order", drain_log[6'(base + i)], 16'h60 + 16'(i));
         chk("t5_mem", mem[8'h60 + 8'(i)], 16'h6000 + 16'(i) * 16'h0101);
      end

      // Three stores pending behind a debug read, then asynchronous reset.
      for (int i = 0; i < 3; i++)
         run_vec(mk("t6_st", 1, 1, 16'h70 + 16'(i), 16'h7000 + 16'(i), 1, 0, 16'h30, 16'h0,
                    1, 0, 16'h0, 0, 16'h30, 16'h0, (i == 0)));
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst.sb_empty", {15'd0, sb_empty}, 16'd1);
      chk("t6_rst.mem_we",   {15'd0, mem_we},   16'd0);
      dbg_valid = 1'b0;
      #1;
      chk("t6_nodbg.mem_we", {15'd0, mem_we}, 16'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         chk("t6_mem", mem[8'h70 + 8'(i)], 16'hDEAD);
      run_vec(mk("t6_ld70", 1, 0, 16'h70, 16'h0, 0, 0, 16'h0, 16'h0,
                 1, 1, 16'hDEAD, 0, 16'h70, 16'h0, 1));
      run_vec(mk("t6_idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0,
                 1, 0, 16'h0, 0, 16'h0, 16'h0, 1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
